activity_tracker: RTL and testbench

// - Parametrised step/activity tracker, successor to the fixed-constant pedometer core.
// - Counts rising edges of an external step pulse, gated by a run/hold FSM.
// - Derives distance, goal flag, initial-activity seconds and sustained high-activity time.
// - Rotates a display-select code for the seven-segment mux.
// - Time base is an external 1-second strobe; the block has no internal second counter.

---
 rtl/activity_tracker.sv | 196 +++++++++++++++++++
 tb/tb_activity_tracker.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/activity_tracker.sv
// activity_tracker: step/activity tracker driven by an external step pulse and 1-second strobe.
//
// Counts rising edges of PULSE while the run/hold FSM is in RUN. From those edges it derives
// total steps, a sticky goal flag, distance in tenths, the number of qualifying seconds in an
// initial window, and credited sustained high-activity time. It also rotates a display-select
// code once every DISP_SECS seconds. Seconds are delimited by SEC_TICK and are only closed while
// running.
//
// Ports:
//   CLK                 system clock, all logic on posedge
//   RESET               synchronous active-high reset, overrides everything
//   START               run enable level (IDLE->RUN, RUN<->HOLD)
//   PULSE               step input level; one step per 0->1 transition
//   SEC_TICK            one-cycle strobe marking the end of each second
//   state               FSM state: 00 IDLE, 01 RUN, 10 HOLD
//   step_count          total steps, saturating
//   SI                  goal flag, set once step_count > GOAL, sticky until RESET
//   distance            distance in tenths, saturating
//   init_count          qualifying seconds inside the initial window, saturating at 15
//   high_activity_time  credited high-activity seconds, saturating
//   disp_sel            display mode select, wraps modulo NUM_DISP
module activity_tracker #(
    parameter int unsigned STEP_W         = 32,
    parameter int unsigned GOAL           = 10000,
    parameter int unsigned STEPS_PER_DIST = 2048,
    parameter int unsigned DIST_W         = 16,
    parameter int unsigned RATE_W         = 12,
    parameter int unsigned SEC_W          = 16,
    parameter int unsigned INIT_WINDOW    = 10,
    parameter int unsigned INIT_THRESH    = 32,
    parameter int unsigned HIGH_THRESH    = 64,
    parameter int unsigned HIGH_RUN       = 60,
    parameter int unsigned NUM_DISP       = 4,
    parameter int unsigned DISP_SECS      = 2,
    localparam int unsigned DispW         = (NUM_DISP > 1) ? $clog2(NUM_DISP) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              PULSE,
    input  logic              SEC_TICK,
    output logic [1:0]        state,
    output logic [STEP_W-1:0] step_count,
    output logic              SI,
    output logic [DIST_W-1:0] distance,
    output logic [3:0]        init_count,
    output logic [SEC_W-1:0]  high_activity_time,
    output logic [DispW-1:0]  disp_sel
);

    localparam int unsigned DistSubW = (STEPS_PER_DIST > 1) ? $clog2(STEPS_PER_DIST) : 1;
    localparam int unsigned DispCntW = $clog2(DISP_SECS + 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHold = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic                pulse_q, pulse_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                si_q, si_d;
    logic [DistSubW-1:0] dist_sub_q, dist_sub_d;
    logic [DIST_W-1:0]   dist_q, dist_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic [SEC_W-1:0]    sec_q, sec_d;
    logic [3:0]          init_q, init_d;
    logic [SEC_W-1:0]    run_q, run_d;
    logic [SEC_W-1:0]    high_q, high_d;
    logic [DispCntW-1:0] disp_cnt_q, disp_cnt_d;
    logic [DispW-1:0]    disp_sel_q, disp_sel_d;

    logic                edge_cnt;
    logic                tick_run;
    logic [RATE_W-1:0]   eff_rate;
    logic [SEC_W-1:0]    run_inc;
    logic [SEC_W-1:0]    high_add;
    logic [SEC_W:0]      high_sum;

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (START)  state_d = StRun;
            StRun:   if (!START) state_d = StHold;
            StHold:  if (START)  state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pulse_d    = PULSE;
        step_d     = step_q;
        si_d       = si_q;
        dist_sub_d = dist_sub_q;
        dist_d     = dist_q;
        rate_d     = rate_q;
        sec_d      = sec_q;
        init_d     = init_q;
        run_d      = run_q;
        high_d     = high_q;
        disp_cnt_d = disp_cnt_q;
        disp_sel_d = disp_sel_q;
        run_inc    = '0;
        high_add   = '0;
        high_sum   = '0;

        edge_cnt = PULSE & ~pulse_q & (state_q == StRun);
        tick_run = SEC_TICK & (state_q == StRun);
        // An edge coincident with the tick belongs to the closing second.
        eff_rate = (edge_cnt && rate_q != '1) ? rate_q + 1'b1 : rate_q;

        if (edge_cnt) begin
            if (step_q != '1) step_d = step_q + 1'b1;
            rate_d = eff_rate;
            if (dist_sub_q == DistSubW'(STEPS_PER_DIST - 1)) begin
                dist_sub_d = '0;
                if (dist_q != '1) dist_d = dist_q + 1'b1;
            end else begin
                dist_sub_d = dist_sub_q + 1'b1;
            end
        end

        si_d = si_q | (step_d > STEP_W'(GOAL));

        if (tick_run) begin
            if (sec_q < SEC_W'(INIT_WINDOW) && eff_rate > RATE_W'(INIT_THRESH) && init_q != 4'hF)
                init_d = init_q + 4'd1;

            if (eff_rate >= RATE_W'(HIGH_THRESH)) begin
                run_inc = (run_q != '1) ? run_q + 1'b1 : run_q;
                run_d   = run_inc;
                // Nothing is credited until the run is long enough; then the whole run at once.
                if (run_inc == SEC_W'(HIGH_RUN))     high_add = SEC_W'(HIGH_RUN);
                else if (run_inc > SEC_W'(HIGH_RUN)) high_add = SEC_W'(1);
                high_sum = {1'b0, high_q} + {1'b0, high_add};
                high_d   = high_sum[SEC_W] ? '1 : high_sum[SEC_W-1:0];
            end else begin
                run_d = '0;
            end

            if (disp_cnt_q + 1'b1 >= DispCntW'(DISP_SECS)) begin
                disp_cnt_d = '0;
                disp_sel_d = (disp_sel_q == DispW'(NUM_DISP - 1)) ? '0 : disp_sel_q + 1'b1;
            end else begin
                disp_cnt_d = disp_cnt_q + 1'b1;
            end

            if (sec_q != '1) sec_d = sec_q + 1'b1;
            rate_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            // Starts high so a PULSE held across reset is not seen as an edge.
            pulse_q    <= 1'b1;
            step_q     <= '0;
            si_q       <= 1'b0;
            dist_sub_q <= '0;
            dist_q     <= '0;
            rate_q     <= '0;
            sec_q      <= '0;
            init_q     <= '0;
            run_q      <= '0;
            high_q     <= '0;
            disp_cnt_q <= '0;
            disp_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            pulse_q    <= pulse_d;
            step_q     <= step_d;
            si_q       <= si_d;
            dist_sub_q <= dist_sub_d;
            dist_q     <= dist_d;
            rate_q     <= rate_d;
            sec_q      <= sec_d;
            init_q     <= init_d;
            run_q      <= run_d;
            high_q     <= high_d;
            disp_cnt_q <= disp_cnt_d;
            disp_sel_q <= disp_sel_d;
        end
    end

    assign state              = state_q;
    assign step_count         = step_q;
    assign SI                 = si_q;
    assign distance           = dist_q;
    assign init_count         = init_q;
    assign high_activity_time = high_q;
    assign disp_sel           = disp_sel_q;

endmodule

// File: tb/tb_activity_tracker.sv
// tb_activity_tracker: directed stimulus with a scoreboard queue of expected output values.
// The stimulus process pushes expectations; a monitor pops one per falling edge and compares.
module tb_activity_tracker;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic        PULSE;
    logic        SEC_TICK;
    logic [1:0]  state;
    logic [31:0] step_count;
    logic        SI;
    logic [15:0] distance;
    logic [3:0]  init_count;
    logic [15:0] high_activity_time;
    logic [1:0]  disp_sel;

    activity_tracker dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .START              (START),
        .PULSE              (PULSE),
        .SEC_TICK           (SEC_TICK),
        .state              (state),
        .step_count         (step_count),
        .SI                 (SI),
        .distance           (distance),
        .init_count         (init_count),
        .high_activity_time (high_activity_time),
        .disp_sel           (disp_sel)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef enum int {FState, FStep, FSi, FDist, FInit, FHigh, FDisp} field_e;

    typedef struct {
        field_e  id;
        longint  exp;
        string   name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic longint actual(field_e id);
        case (id)
            FState:  return longint'(state);
            FStep:   return longint'(step_count);
            FSi:     return longint'(SI);
            FDist:   return longint'(distance);
            FInit:   return longint'(init_count);
            FHigh:   return longint'(high_activity_time);
            FDisp:   return longint'(disp_sel);
            default: return -1;
        endcase
    endfunction

    // Monitor: one comparison per falling edge while expectations are pending.
    initial begin
        exp_t   e;
        longint a;
        forever begin
            @(negedge CLK);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                a = actual(e.id);
                checks++;
                if (a != e.exp) begin
                    failures++;
                    $display("FAIL %s: got %0d expected %0d at %0t", e.name, a, e.exp, $time);
                end
            end
        end
    end

    task automatic expect_val(input field_e id, input longint v, input string name);
        exp_t e;
        e.id   = id;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    // Hold inputs stable until the monitor has consumed every pending expectation.
    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        cyc();
        cyc();
        RESET = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic pulses(input int n, input int w);
        for (int i = 0; i < n; i++) begin
            PULSE = 1'b1;
            repeat (w) cyc();
            PULSE = 1'b0;
            repeat (w) cyc();
        end
    endtask

    task automatic tick();
        SEC_TICK = 1'b1;
        cyc();
        SEC_TICK = 1'b0;
        cyc();
    endtask

    task automatic edge_tick();
        PULSE    = 1'b1;
        SEC_TICK = 1'b1;
        cyc();
        PULSE    = 1'b0;
        SEC_TICK = 1'b0;
        cyc();
    endtask

    initial begin
        RESET    = 1'b1;
        START    = 1'b0;
        PULSE    = 1'b0;
        SEC_TICK = 1'b0;
        cyc();
        cyc();

        // Reset state
        expect_val(FState, 0, "rst_state");
        expect_val(FStep, 0, "rst_step");
        expect_val(FSi, 0, "rst_si");
        expect_val(FDist, 0, "rst_dist");
        expect_val(FInit, 0, "rst_init");
        expect_val(FHigh, 0, "rst_high");
        expect_val(FDisp, 0, "rst_disp");
        drain();
        RESET = 1'b0;
        cyc();
        expect_val(FState, 0, "idle_hold");
        drain();

        // Goal and distance
        START = 1'b1;
        cyc();
        expect_val(FState, 1, "run_state");
        drain();
        pulses(10000, 2);
        expect_val(FStep, 10000, "step_10000");
        expect_val(FSi, 0, "si_at_goal");
        drain();
        pulses(1, 2);
        expect_val(FStep, 10001, "step_10001");
        expect_val(FSi, 1, "si_above_goal");
        expect_val(FDist, 4, "dist_10001");
        drain();

        // PULSE held high across reset release
        PULSE = 1'b1;
        do_reset();
        cyc();
        cyc();
        expect_val(FStep, 0, "held_pulse_step");
        expect_val(FSi, 0, "held_pulse_si");
        expect_val(FState, 1, "held_pulse_state");
        drain();
        PULSE = 1'b0;
        cyc();
        PULSE = 1'b1;
        cyc();
        PULSE = 1'b0;
        cyc();
        expect_val(FStep, 1, "first_edge_step");
        drain();

        // HOLD freezes steps, rate, seconds and display
        do_reset();
        pulses(20, 1);
        START = 1'b0;
        cyc();
        expect_val(FState, 2, "hold_state");
        drain();
        for (int i = 0; i < 3; i++) begin
            pulses(5, 1);
            tick();
        end
        expect_val(FState, 2, "hold_state_after");
        expect_val(FStep, 20, "hold_step");
        expect_val(FDisp, 0, "hold_disp");
        expect_val(FInit, 0, "hold_init");
        drain();
        START = 1'b1;
        cyc();
        expect_val(FState, 1, "resume_state");
        drain();
        pulses(13, 1);
        tick();
        expect_val(FInit, 1, "resume_rate_kept");
        expect_val(FStep, 33, "resume_step");
        expect_val(FDisp, 0, "resume_disp0");
        drain();
        tick();
        expect_val(FDisp, 1, "resume_disp1");
        drain();

        // 40 edges/s for 12 seconds
        do_reset();
        for (int i = 0; i < 12; i++) begin
            pulses(40, 1);
            tick();
        end
        expect_val(FInit, 10, "init_window");
        expect_val(FHigh, 0, "init_high");
        expect_val(FDisp, 2, "init_disp");
        expect_val(FStep, 480, "init_step");
        drain();

        // Coincident edge counts toward the closing second; threshold is strict
        do_reset();
        pulses(32, 1);
        edge_tick();
        expect_val(FInit, 1, "coinc_init");
        expect_val(FStep, 33, "coinc_step");
        drain();
        pulses(32, 1);
        tick();
        expect_val(FInit, 1, "init_thresh_strict");
        drain();

        // Sustained high activity
        do_reset();
        for (int i = 0; i < 59; i++) begin
            pulses(64, 1);
            tick();
        end
        expect_val(FHigh, 0, "high_run59");
        drain();
        pulses(64, 1);
        tick();
        expect_val(FHigh, 60, "high_run60");
        expect_val(FInit, 10, "high_init");
        drain();
        pulses(63, 1);
        edge_tick();
        expect_val(FHigh, 61, "high_coinc61");
        drain();
        pulses(63, 1);
        tick();
        expect_val(FHigh, 61, "high_break63");
        drain();
        for (int i = 0; i < 59; i++) begin
            pulses(64, 1);
            tick();
        end
        expect_val(FHigh, 61, "high_rerun59");
        drain();
        pulses(64, 1);
        tick();
        expect_val(FHigh, 121, "high_final");
        expect_val(FStep, 7807, "high_step");
        expect_val(FDist, 3, "high_dist");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
